seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Multi-cycle radix-2 restoring divider for the m_cpu execute stage. It computes
//  quotient and remainder of rs1_reg / rs2_reg, one quotient bit per clock.
//  It supports unsigned and two's-complement signed operands.
//  Replaces the repeated-subtraction divider: latency is fixed and independent of data.
//  Division by zero and signed overflow follow RISC-V M-extension result rules.
// PARAMETERS
//  N          16  operand/result width in bits; minimum 2
//  SIGNED_EN   1  1 = signed_in honoured; 0 = signed_in ignored, always unsigned
// PORTS
//  clk        in   1  clock, rising edge
//  rstn       in   1  reset, asynchronous, active-low
//  req        in   1  start request; sampled only in IDLE
//  signed_in  in   1  1 = treat operands as signed; latched with req
//  rs1_reg    in   N  dividend; latched with req
//  rs2_reg    in   N  divisor; latched with req
//  busy       out  1  high from the accepting edge until the edge that asserts ready
//  div_rd     out  N  quotient; held until the next result
//  rem        out  N  remainder; sign follows the dividend; held until the next result
//  ready      out  1  one-cycle pulse: div_rd/rem/exception valid
//  exception  out  1  divide-by-zero flag; valid with ready, held until the next result
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy, ready, exception, div_rd, rem all 0;
//   internal regs cleared. Reset mid-operation aborts with no ready pulse.
//  FSM states: IDLE, DIVIDE, FIX.
//  IDLE:
//   - Default: ready=0.
//   - req=1 and rs2_reg==0 (edge 0): at edge 1 drive div_rd=all-ones, rem=rs1_reg,
//     exception=1, ready=1. State stays IDLE; busy stays 0.
//   - req=1, signed mode, rs1_reg==MIN (1<<N-1), rs2_reg==all-ones: at edge 1 drive
//     div_rd=rs1_reg, rem=0, exception=0, ready=1.
//   - Any other req: latch |rs1|, |rs2|, the quotient sign (s1^s2) and the remainder
//     sign (s1). Magnitudes are taken only in signed mode. Clear partial remainder
//     P (N+1 bits) and counter. Set busy=1 and go to DIVIDE.
//  DIVIDE: exactly N cycles, MSB first.
//   - P = {P[N-1:0], A[N-1]}; A <<= 1.
//   - If P >= {0,B}: P -= B and A[0] = 1; else A[0] = 0.
//   - Counter counts 0..N-1; at N-1 go to FIX.
//  FIX (one cycle):
//   - div_rd = qsign ? -A : A; rem = rsign ? -P[N-1:0] : P[N-1:0].
//   - exception=0, ready=1, busy=0, go to IDLE.
//  Latency: accept at edge 0; result and ready at edge N+1; ready drops at edge N+2.
//   - Special cases (zero divisor, signed overflow) complete at edge 1.
//  ready is a single-cycle pulse. No backpressure; the consumer must capture on ready.
//  req while busy=1 is ignored, not queued.
//  req on the cycle ready=1 is accepted (back-to-back, IDLE already re-entered).
//  Operand inputs may change freely after the accepting edge.
//  Result arithmetic is modulo 2^N; remainder magnitude is always < |divisor|.
// TESTING (N=16)
//  1 unsigned 100/7 -> div_rd=14, rem=2, ready at edge 17 for exactly 1 cycle, busy edges 0..17
//  2 signed -100/7 (0xFF9C/0x0007) -> div_rd=0xFFF2, rem=0xFFFE; signed 100/-7 -> 0xFFF2, 0x0002
//  3 0x1234/0 (either mode) -> div_rd=0xFFFF, rem=0x1234, exception=1, ready at edge 1
//  4 signed 0x8000/0xFFFF -> div_rd=0x8000, rem=0, exception=0; unsigned same -> div_rd=0, rem=0x8000
//  5 req held high during DIVIDE with new operands -> ignored; back-to-back req in ready cycle accepted
//  6 rstn low at edge 8 of a divide -> all outputs 0, no ready pulse; next req completes normally
//  plus randomized compare vs. / and % model in both modes, incl. 0xFFFF/1, 0/x, x/x

Source files
------------

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per clock, signed/unsigned with RISC-V M special cases.
// Latency N+1 edges (special cases 1); single-cycle ready pulse, no backpressure, req ignored while busy.
module seq_divider #(
  parameter int N         = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         req,
  input  logic         signed_in,
  input  logic [N-1:0] rs1_reg,
  input  logic [N-1:0] rs2_reg,
  output logic         busy,
  output logic [N-1:0] div_rd,
  output logic [N-1:0] rem,
  output logic         ready,
  output logic         exception
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [N-1:0] MIN  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ONES = '1;

  typedef enum logic [1:0] {IDLE, DIVIDE, FIX} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  a, b;
  logic [N:0]    p;
  logic [CW-1:0] cnt;
  logic          qsign, rsign, spec_pend, spec_exc;

  logic          sgn, s1, s2, zero_div, ovf, special, accept, finish, ge;
  logic [N-1:0]  mag1, mag2;
  logic [N:0]    p_sh;

  always_comb begin
    sgn      = SIGNED_EN && signed_in;
    s1       = sgn & rs1_reg[N-1];
    s2       = sgn & rs2_reg[N-1];
    mag1     = s1 ? -rs1_reg : rs1_reg;
    mag2     = s2 ? -rs2_reg : rs2_reg;
    zero_div = (rs2_reg == '0);
    ovf      = sgn && (rs1_reg == MIN) && (rs2_reg == ONES);
    special  = zero_div || ovf;
    // spec_pend holds IDLE for the one cycle a special-case result is in flight
    accept   = (state == IDLE) && !spec_pend && req;
    finish   = (state == FIX) || spec_pend;
    p_sh     = {p[N-1:0], a[N-1]};
    ge       = (p_sh >= {1'b0, b});
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !special) state_nxt = DIVIDE;
      DIVIDE:  if (cnt == CW'(N-1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a         <= '0;
      b         <= '0;
      p         <= '0;
      cnt       <= '0;
      qsign     <= 1'b0;
      rsign     <= 1'b0;
      spec_pend <= 1'b0;
      spec_exc  <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      exception <= 1'b0;
      div_rd    <= '0;
      rem       <= '0;
    end else begin
      spec_pend <= 1'b0;
      ready     <= finish;
      if (finish) begin
        div_rd    <= qsign ? -a : a;
        rem       <= rsign ? -p[N-1:0] : p[N-1:0];
        exception <= spec_exc;
        busy      <= 1'b0;
      end
      if (accept) begin
        cnt <= '0;
        if (special) begin
          // results staged in a/p with signs cleared so the common finish path passes them through
          spec_pend <= 1'b1;
          spec_exc  <= zero_div;
          qsign     <= 1'b0;
          rsign     <= 1'b0;
          a         <= zero_div ? ONES : rs1_reg;
          p         <= zero_div ? {1'b0, rs1_reg} : '0;
        end else begin
          a        <= mag1;
          b        <= mag2;
          p        <= '0;
          qsign    <= s1 ^ s2;
          rsign    <= s1;
          spec_exc <= 1'b0;
          busy     <= 1'b1;
        end
      end else if (state == DIVIDE) begin
        cnt <= cnt + 1'b1;
        if (ge) begin
          p <= p_sh - {1'b0, b};
          a <= {a[N-2:0], 1'b1};
        end else begin
          p <= p_sh;
          a <= {a[N-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N=16): results checked on ready against a / and % model.
module tb_seq_divider;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] r;
    logic        exc;
  } res_t;

  logic        clk = 1'b0;
  logic        rstn, req, sgn, busy, ready, exception;
  logic [15:0] rs1, rs2, div_rd, rem;

  int   checks = 0;
  int   failures = 0;
  res_t sb[$];
  res_t mexp;

  seq_divider #(.N(16), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .req(req), .signed_in(sgn),
    .rs1_reg(rs1), .rs2_reg(rs2), .busy(busy), .div_rd(div_rd),
    .rem(rem), .ready(ready), .exception(exception)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    res_t m;
    int   sa, sbv;
    if (b == 16'h0) begin
      m.q = 16'hFFFF; m.r = a; m.exc = 1'b1;
    end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
      m.q = 16'h8000; m.r = 16'h0; m.exc = 1'b0;
    end else if (s) begin
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      m.q = 16'(sa / sbv); m.r = 16'(sa % sbv); m.exc = 1'b0;
    end else begin
      m.q = a / b; m.r = a % b; m.exc = 1'b0;
    end
    return m;
  endfunction

  function automatic int exp_lat(input logic [15:0] a, input logic [15:0] b, input logic s);
    return (b == 16'h0 || (s && a == 16'h8000 && b == 16'hFFFF)) ? 1 : 17;
  endfunction

  always @(negedge clk) begin
    if (rstn && ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result got q=%h r=%h exc=%b required no result", div_rd, rem, exception);
      end else begin
        mexp = sb.pop_front();
        if ({div_rd, rem, exception} !== {mexp.q, mexp.r, mexp.exc}) begin
          failures++;
          $display("FAIL result got q=%h r=%h exc=%b required q=%h r=%h exc=%b",
                   div_rd, rem, exception, mexp.q, mexp.r, mexp.exc);
        end
      end
    end
  end

  // Presents an operation for the next rising edge (edge 0), then scrambles the operand inputs.
  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic s);
    rs1 = a; rs2 = b; sgn = s; req = 1'b1;
    sb.push_back(model(a, b, s));
    @(posedge clk);
    #1;
    req = 1'b0;
    rs1 = 16'($urandom); rs2 = 16'($urandom); sgn = 1'($urandom_range(0, 1));
  endtask

  // Returns the edge index (0 = the edge just past) at which ready is seen; -1 on timeout.
  task automatic wait_ready(output int lat, output logic busy_ok);
    lat = -1; busy_ok = 1'b1;
    for (int e = 0; e < 40; e++) begin
      if (e > 0) @(posedge clk);
      @(negedge clk);
      if (ready) begin
        lat = e;
        busy_ok = busy_ok & !busy;
        break;
      end
      busy_ok = busy_ok & busy;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = 1'b0; sgn = 1'b0; rs1 = 16'h0; rs2 = 16'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, ready, exception, div_rd, rem} !== 35'h0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%b ready=%b exc=%b q=%h r=%h required all 0",
               busy, ready, exception, div_rd, rem);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, ready} !== 2'b00) begin
      failures++;
      $display("FAIL post_reset_idle got busy=%b ready=%b required 0 0", busy, ready);
    end
  endtask

  task automatic test_unsigned_basic();
    int lat; logic bok;
    accept(16'd100, 16'd7, 1'b0);
    wait_ready(lat, bok);
    checks++;
    if (lat !== 17) begin failures++; $display("FAIL basic_latency got %0d required 17", lat); end
    checks++;
    if (bok !== 1'b1) begin failures++; $display("FAIL basic_busy_window got %b required 1", bok); end
    @(negedge clk);
    checks++;
    if ({ready, busy} !== 2'b00) begin
      failures++; $display("FAIL ready_pulse_width got ready=%b busy=%b required 0 0", ready, busy);
    end
  endtask

  task automatic test_signed();
    int lat; logic bok;
    logic [15:0] a [2] = '{16'hFF9C, 16'd100};
    logic [15:0] b [2] = '{16'h0007, 16'hFFF9};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      accept(a[i], b[i], 1'b1);
      wait_ready(lat, bok);
      checks++;
      if (lat !== 17 || bok !== 1'b1) begin
        failures++; $display("FAIL signed_timing[%0d] got lat=%0d busy_ok=%b required 17 1", i, lat, bok);
      end
    end
  endtask

  task automatic test_special_cases();
    int lat; logic bok;
    logic [15:0] a [4] = '{16'h1234, 16'h1234, 16'h8000, 16'h8000};
    logic [15:0] b [4] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF};
    logic        s [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      accept(a[i], b[i], s[i]);
      wait_ready(lat, bok);
      checks++;
      if (lat !== exp_lat(a[i], b[i], s[i])) begin
        failures++; $display("FAIL special_latency[%0d] got %0d required %0d", i, lat, exp_lat(a[i], b[i], s[i]));
      end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL special_busy[%0d] got %b required 0", i, busy); end
    end
  endtask

  task automatic test_req_ignored();
    int lat; int extra; logic bok;
    @(negedge clk);
    accept(16'hBEEF, 16'd13, 1'b0);
    req = 1'b1; rs1 = 16'h0055; rs2 = 16'h0003; sgn = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    req = 1'b0;
    wait_ready(lat, bok);
    checks++;
    if (lat !== 9) begin failures++; $display("FAIL held_req_latency got %0d required 9", lat); end
    extra = 0;
    repeat (20) begin @(negedge clk); if (ready) extra++; end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL held_req_queued got %0d extra readies required 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat; logic bok;
    @(negedge clk);
    accept(16'd1000, 16'd3, 1'b0);
    wait_ready(lat, bok);
    accept(16'hFFF0, 16'd16, 1'b1);
    wait_ready(lat, bok);
    checks++;
    if (lat !== 17 || bok !== 1'b1) begin
      failures++; $display("FAIL b2b_normal got lat=%0d busy_ok=%b required 17 1", lat, bok);
    end
    accept(16'd5, 16'd0, 1'b0);
    wait_ready(lat, bok);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL b2b_zero_div got lat=%0d required 1", lat); end
    accept(16'd77, 16'd5, 1'b0);
    wait_ready(lat, bok);
    checks++;
    if (lat !== 17) begin failures++; $display("FAIL b2b_after_special got lat=%0d required 17", lat); end
  endtask

  task automatic test_reset_abort();
    int lat; int extra; logic bok;
    res_t dropped;
    @(negedge clk);
    accept(16'hABCD, 16'h0013, 1'b0);
    repeat (7) @(posedge clk);
    #3;
    rstn = 1'b0;
    dropped = sb.pop_back();
    #1;
    checks++;
    if ({busy, ready, exception, div_rd, rem} !== 35'h0) begin
      failures++;
      $display("FAIL abort_outputs got busy=%b ready=%b exc=%b q=%h r=%h required all 0 (dropped q=%h)",
               busy, ready, exception, div_rd, rem, dropped.q);
    end
    @(negedge clk);
    rstn = 1'b1;
    extra = 0;
    repeat (20) begin @(negedge clk); if (ready) extra++; end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL abort_ready got %0d pulses required 0", extra); end
    accept(16'h0F0F, 16'h0011, 1'b0);
    wait_ready(lat, bok);
    checks++;
    if (lat !== 17) begin failures++; $display("FAIL abort_recover_latency got %0d required 17", lat); end
  endtask

  task automatic test_random();
    int lat; logic bok;
    logic [15:0] a, b;
    logic s;
    for (int i = 0; i < 160; i++) begin
      a = 16'($urandom);
      s = 1'(i % 2);
      case (i % 8)
        0: b = 16'($urandom_range(1, 15));
        1: b = a;
        2: begin a = 16'hFFFF; b = 16'd1; end
        3: begin a = 16'h0; b = 16'($urandom); end
        4: b = 16'h0;
        5: b = 16'hFFFF;
        default: b = 16'($urandom);
      endcase
      @(negedge clk);
      accept(a, b, s);
      wait_ready(lat, bok);
      checks++;
      if (lat !== exp_lat(a, b, s)) begin
        failures++; $display("FAIL random_latency a=%h b=%h s=%b got %0d required %0d", a, b, s, lat, exp_lat(a, b, s));
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_special_cases();
    test_req_ignored();
    test_back_to_back();
    test_reset_abort();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_drain got %0d pending required 0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
